rotate_scanout: RTL and testbench

// Read side of the double-buffered rotated frame buffer. Once the writer finishes a rotated frame into one half of the

---
 rtl/rotate_scanout.sv | 144 ++++++++++++++
 tb/tb_rotate_scanout.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_scanout.sv
// rtl/rotate_scanout.sv - raster scan-out of the rotated double buffer with scaler-oriented timing
module rotate_scanout #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int DEPTH   = 8,
  parameter int MARGIN  = 4,
  parameter int AW      = 18,
  parameter int HBL     = 17,
  parameter int VBL_MIN = 16,
  parameter int VBL_MAX = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_out,
  input  logic             wr_frame_done,
  input  logic             wr_buf,
  output logic             rd_buf,
  output logic [AW-1:0]    rd_addr,
  input  logic [DEPTH-1:0] rd_data,
  output logic [DEPTH-1:0] video_out,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank,
  output logic             vblank,
  output logic [7:0]       frames_dropped
);

  localparam int LT   = HEIGHT + HBL;
  localparam int YT   = WIDTH + 2 * MARGIN;
  localparam int XCAP = (LT > HEIGHT + 11) ? LT : HEIGHT + 11;
  localparam int VCAP = (VBL_MAX > 12) ? VBL_MAX : 12;
  localparam int XW   = $clog2(XCAP);
  localparam int YW   = $clog2(YT + 1);
  localparam int VW   = $clog2(VCAP + 1);

  localparam logic [XW-1:0] X_LAST = XW'(LT - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(HEIGHT);
  localparam logic [XW-1:0] X_HS0  = XW'(HEIGHT + 8);
  localparam logic [XW-1:0] X_HS1  = XW'(HEIGHT + 10);
  localparam logic [YW-1:0] Y_C0   = YW'(MARGIN);
  localparam logic [YW-1:0] Y_C1   = YW'(WIDTH + MARGIN);
  localparam logic [YW-1:0] Y_LAST = YW'(YT - 1);
  localparam logic [VW-1:0] V_MIN  = VW'(VBL_MIN);
  localparam logic [VW-1:0] V_MAX  = VW'(VBL_MAX);
  localparam logic [VW-1:0] V_S0   = VW'(10);
  localparam logic [VW-1:0] V_S1   = VW'(12);
  localparam logic [AW-1:0] BASE1  = AW'(WIDTH * HEIGHT);

  localparam logic [0:0] ST_VBLANK = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  if (WIDTH * HEIGHT >= 2 ** AW) begin : g_bad_aw
    $error("rotate_scanout: WIDTH*HEIGHT does not fit in AW address bits");
  end

  logic [0:0]    state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [VW-1:0] vl;
  logic          pending;
  logic          pend_buf;

  logic          pix;
  logic          line_end;
  logic          pend_now;
  logic          pbuf_now;
  logic [VW-1:0] vl_inc;
  logic          do_swap;
  logic          do_repeat;

  // A done pulse on the swap clk is folded straight into the swap decision.
  always_comb begin
    pix       = (state == ST_ACTIVE) && (y >= Y_C0) && (y < Y_C1) && (x < X_ACT);
    line_end  = (x == X_LAST);
    pend_now  = pending | wr_frame_done;
    pbuf_now  = wr_frame_done ? wr_buf : pend_buf;
    vl_inc    = vl + VW'(1);
    do_swap   = ce_out && line_end && (state == ST_VBLANK) && (vl_inc >= V_MIN) && pend_now;
    do_repeat = ce_out && line_end && (state == ST_VBLANK) && (vl_inc == V_MAX) && !pend_now;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_VBLANK;
      x              <= '0;
      y              <= '0;
      vl             <= '0;
      pending        <= 1'b0;
      pend_buf       <= 1'b0;
      rd_buf         <= 1'b0;
      rd_addr        <= '0;
      video_out      <= '0;
      hsync          <= 1'b0;
      vsync          <= 1'b0;
      hblank         <= 1'b1;
      vblank         <= 1'b1;
      frames_dropped <= '0;
    end else begin
      if (do_swap) begin
        pending <= 1'b0;
        rd_buf  <= pbuf_now;
      end else if (wr_frame_done) begin
        pending  <= 1'b1;
        pend_buf <= wr_buf;
        if (pending && frames_dropped != 8'hff) frames_dropped <= frames_dropped + 8'd1;
      end

      if (ce_out) begin
        // Outputs describe the pixel at the current x/y; rd_addr already holds its address.
        video_out <= pix ? rd_data : '0;
        hblank    <= (x >= X_ACT);
        hsync     <= (x >= X_HS0) && (x < X_HS1);
        vblank    <= (state == ST_VBLANK);
        vsync     <= (state == ST_VBLANK) && (vl >= V_S0) && (vl < V_S1);
        if (pix) rd_addr <= rd_addr + AW'(1);

        if (!line_end) begin
          x <= x + XW'(1);
        end else begin
          x <= '0;
          if (state == ST_ACTIVE) begin
            if (y == Y_LAST) begin
              state <= ST_VBLANK;
              vl    <= '0;
            end else begin
              y <= y + YW'(1);
            end
          end else if (do_swap) begin
            rd_addr <= pbuf_now ? BASE1 : '0;
            y       <= '0;
            state   <= ST_ACTIVE;
          end else if (do_repeat) begin
            rd_addr <= rd_buf ? BASE1 : '0;
            y       <= '0;
            state   <= ST_ACTIVE;
          end else begin
            vl <= vl_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rotate_scanout.sv
// tb/tb_rotate_scanout.sv - directed bench for rotate_scanout on a small 8x4 frame
module tb_rotate_scanout;
  // HBL widened so the hsync window at x=HEIGHT+8 exists inside the line
  localparam int WIDTH   = 8;
  localparam int HEIGHT  = 4;
  localparam int DEPTH   = 8;
  localparam int MARGIN  = 1;
  localparam int AW      = 8;
  localparam int HBL     = 12;
  localparam int VBL_MIN = 2;
  localparam int VBL_MAX = 6;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             ce_out;
  logic             wr_frame_done;
  logic             wr_buf;
  logic             rd_buf;
  logic [AW-1:0]    rd_addr;
  logic [DEPTH-1:0] rd_data;
  logic [DEPTH-1:0] video_out;
  logic             hsync;
  logic             vsync;
  logic             hblank;
  logic             vblank;
  logic [7:0]       frames_dropped;

  always #5 clk = ~clk;

  // RAM preloaded with its own address as data
  assign rd_data = DEPTH'(rd_addr);

  rotate_scanout #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .DEPTH(DEPTH), .MARGIN(MARGIN), .AW(AW),
    .HBL(HBL), .VBL_MIN(VBL_MIN), .VBL_MAX(VBL_MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce_out(ce_out), .wr_frame_done(wr_frame_done),
    .wr_buf(wr_buf), .rd_buf(rd_buf), .rd_addr(rd_addr), .rd_data(rd_data),
    .video_out(video_out), .hsync(hsync), .vsync(vsync), .hblank(hblank),
    .vblank(vblank), .frames_dropped(frames_dropped)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cap_pix [10];
  logic [15:0] cap_hb;
  logic [15:0] cap_hs;

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_line(input int base, input int y);
    logic [31:0] w;
    w = '0;
    if (y >= 1 && y <= 8)
      for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(base + 4 * (y - 1) + i);
    return w;
  endfunction

  // Returns the number of samples until vblank falls; optional one-clk done pulse at sample pulse_at.
  task automatic wait_vblank_end(input int pulse_at, input logic pbuf, output int n, output logic moved);
    n = 0;
    moved = 1'b0;
    while (n < 400) begin
      if (n == pulse_at) begin
        wr_frame_done = 1'b1;
        wr_buf = pbuf;
      end
      @(negedge clk);
      wr_frame_done = 1'b0;
      n++;
      if (rd_addr !== '0) moved = 1'b1;
      if (vblank === 1'b0) break;
    end
  endtask

  // Entered on the sample of pixel (0,0); ends on the sample of pixel (9,15).
  task automatic capture_frame(input logic two_pulses);
    for (int y = 0; y < 10; y++) begin
      for (int x = 0; x < 16; x++) begin
        if (y != 0 || x != 0) @(negedge clk);
        wr_frame_done = 1'b0;
        if (two_pulses && x == 0 && (y == 2 || y == 4)) begin
          wr_frame_done = 1'b1;
          wr_buf = (y == 2);
        end
        if (x < 4) cap_pix[y][8*x +: 8] = video_out;
        if (y == 1) begin
          cap_hb[x] = hblank;
          cap_hs[x] = hsync;
        end
      end
    end
    wr_frame_done = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int base);
    for (int y = 0; y < 10; y++) check(tag, y, cap_pix[y], exp_line(base, y));
  endtask

  // One pixel with ce_out every 4th clk: three idle samples, then the sample after the ce edge.
  task automatic slow_pixel(output logic [7:0] vo, output logic hb, output logic hs,
                            output logic vb, output logic stable, output int hs_clks);
    logic [7:0] v0;
    logic       h0;
    v0 = video_out;
    h0 = hblank;
    stable = 1'b1;
    hs_clks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (video_out !== v0 || hblank !== h0) stable = 1'b0;
      if (hsync === 1'b1) hs_clks++;
    end
    ce_out = 1'b1;
    @(negedge clk);
    ce_out = 1'b0;
    vo = video_out;
    hb = hblank;
    hs = hsync;
    vb = vblank;
    if (hsync === 1'b1) hs_clks++;
  endtask

  int          n;
  logic        moved;
  logic [7:0]  vo;
  logic        hb, hs, vb, st;
  int          hc, hs_total;
  logic        all_stable;
  logic [31:0] slow_word;
  logic [15:0] slow_hb, slow_hs;

  initial begin
    reset_n = 1'b0;
    ce_out = 1'b1;
    wr_frame_done = 1'b0;
    wr_buf = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rd_buf", 0, 32'(rd_buf), 32'd0);
    check("rst_rd_addr", 0, 32'(rd_addr), 32'd0);
    check("rst_video", 0, 32'(video_out), 32'd0);
    check("rst_hsync", 0, 32'(hsync), 32'd0);
    check("rst_vsync", 0, 32'(vsync), 32'd0);
    check("rst_hblank", 0, 32'(hblank), 32'd1);
    check("rst_vblank", 0, 32'(vblank), 32'd1);
    check("rst_dropped", 0, 32'(frames_dropped), 32'd0);

    // No pending frame after reset: VBL_MAX lines, then base 0 repeats
    reset_n = 1'b1;
    wait_vblank_end(-1, 1'b0, n, moved);
    check("vbl_repeat_len", 0, 32'(n), 32'd97);
    check("repeat_rd_buf", 0, 32'(rd_buf), 32'd0);
    capture_frame(1'b0);
    check_frame("frame_base0", 0);
    check("hblank_mask", 0, 32'(cap_hb), 32'h0000fff0);
    check("hsync_mask", 0, 32'(cap_hs), 32'h00003000);

    // Done pulse for half 1 early in vblank: swap after VBL_MIN lines
    wait_vblank_end(3, 1'b1, n, moved);
    check("vbl_swap_len", 0, 32'(n), 32'd33);
    check("swap_rd_buf", 0, 32'(rd_buf), 32'd1);
    capture_frame(1'b1);
    check_frame("frame_base1", 32);
    check("dropped_after_two", 0, 32'(frames_dropped), 32'd1);

    // Latest of the two pulses (half 0) wins
    wait_vblank_end(-1, 1'b0, n, moved);
    check("vbl_latest_len", 0, 32'(n), 32'd33);
    check("latest_rd_buf", 0, 32'(rd_buf), 32'd0);
    capture_frame(1'b0);
    check_frame("frame_latest", 0);

    // Pulse lands on the VBL_MIN wrap clk and joins that swap
    wait_vblank_end(31, 1'b1, n, moved);
    check("vbl_bypass_len", 0, 32'(n), 32'd33);
    check("bypass_rd_buf", 0, 32'(rd_buf), 32'd1);
    check("bypass_dropped", 0, 32'(frames_dropped), 32'd1);
    capture_frame(1'b0);
    check_frame("frame_bypass", 32);

    // ce_out every 4th clk through the repeated frame
    ce_out = 1'b0;
    n = 0;
    vb = 1'b1;
    while (vb === 1'b1 && n < 200) begin
      slow_pixel(vo, hb, hs, vb, st, hc);
      n++;
    end
    check("slow_vbl_len", 0, 32'(n), 32'd97);
    for (int x = 1; x < 16; x++) slow_pixel(vo, hb, hs, vb, st, hc);
    slow_word = '0;
    slow_hb = '0;
    slow_hs = '0;
    all_stable = 1'b1;
    hs_total = 0;
    for (int x = 0; x < 16; x++) begin
      slow_pixel(vo, hb, hs, vb, st, hc);
      if (x < 4) slow_word[8*x +: 8] = vo;
      slow_hb[x] = hb;
      slow_hs[x] = hs;
      all_stable = all_stable & st;
      hs_total += hc;
    end
    check("slow_pixels", 0, slow_word, exp_line(32, 1));
    check("slow_hblank_mask", 0, 32'(slow_hb), 32'h0000fff0);
    check("slow_hsync_mask", 0, 32'(slow_hs), 32'h00003000);
    check("slow_stable", 0, 32'(all_stable), 32'd1);
    check("slow_hsync_clks", 0, 32'(hs_total), 32'd8);

    // Asynchronous reset in the middle of a content line
    ce_out = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_video", 0, 32'(video_out), 32'd38);
    #2 reset_n = 1'b0;
    #1;
    check("arst_rd_buf", 0, 32'(rd_buf), 32'd0);
    check("arst_rd_addr", 0, 32'(rd_addr), 32'd0);
    check("arst_video", 0, 32'(video_out), 32'd0);
    check("arst_hblank", 0, 32'(hblank), 32'd1);
    check("arst_vblank", 0, 32'(vblank), 32'd1);
    check("arst_dropped", 0, 32'(frames_dropped), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_vblank_end(-1, 1'b0, n, moved);
    check("post_rst_vbl_len", 0, 32'(n), 32'd97);
    check("post_rst_addr_idle", 0, 32'(moved), 32'd0);
    check("post_rst_rd_buf", 0, 32'(rd_buf), 32'd0);
    capture_frame(1'b0);
    check_frame("frame_post_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
